// File: rtl/coll_scheduler.sv
// Collect-window sequencer: synchronised start_coll rise to first collect is SYNC_STAGES+3 edges.
// buf_ready low pauses collect with the window count held and sets sticky stalled; nothing is skipped.
module coll_scheduler #(
  parameter int SYNC_STAGES = 2,
  parameter int LEN_W       = 16,
  parameter int CNT_W       = 8
) (
  input  logic             clk350,
  input  logic             rstn,
  input  logic             start_coll,
  input  logic [LEN_W-1:0] cfg_win_len,
  input  logic [LEN_W-1:0] cfg_gap_len,
  input  logic [CNT_W-1:0] cfg_num_win,
  input  logic             buf_ready,
  output logic             collect,
  output logic             win_start,
  output logic [CNT_W-1:0] win_idx,
  output logic             busy,
  output logic             done,
  output logic             aborted,
  output logic             stalled
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ARM     = 3'd1,
    COLLECT = 3'd2,
    GAP     = 3'd3,
    DONE    = 3'd4
  } state_t;

  localparam logic [LEN_W-1:0] LEN_ONE = LEN_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_t state, state_nx;

  logic [SYNC_STAGES-1:0] sync;
  logic [SYNC_STAGES:0]   fill;
  logic                   s_lvl;
  logic                   s_lvl_q;
  logic                   s_rise;
  logic                   s_fall;

  logic [LEN_W-1:0] win_len_q;
  logic [LEN_W-1:0] gap_len_q;
  logic [CNT_W-1:0] num_win_q;
  logic [LEN_W-1:0] rem;
  logic [LEN_W-1:0] gap_cnt;

  logic win_end;
  logic last_win;
  logic gap_end;
  logic run_start;
  logic start_win;
  logic next_win;
  logic abort;

  assign s_lvl = sync[SYNC_STAGES-1];

  // Edges are trusted only once the chain holds real samples, so a level already high at reset release is not a rise.
  always_ff @(posedge clk350 or posedge rstn) begin
    if (rstn) begin
      sync    <= '0;
      fill    <= '0;
      s_lvl_q <= 1'b0;
      s_rise  <= 1'b0;
      s_fall  <= 1'b0;
    end else begin
      sync    <= {sync[SYNC_STAGES-2:0], start_coll};
      fill    <= {fill[SYNC_STAGES-1:0], 1'b1};
      s_lvl_q <= s_lvl;
      s_rise  <= fill[SYNC_STAGES] & s_lvl & ~s_lvl_q;
      s_fall  <= fill[SYNC_STAGES] & ~s_lvl & s_lvl_q;
    end
  end

  assign win_end  = (state == COLLECT) && collect && (rem == '0);
  assign last_win = (num_win_q != '0) && (win_idx == num_win_q - CNT_ONE);
  assign gap_end  = (state == GAP) && (gap_cnt == '0);

  always_ff @(posedge clk350 or posedge rstn) begin
    if (rstn) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx  = state;
    run_start = 1'b0;
    start_win = 1'b0;
    next_win  = 1'b0;
    abort     = 1'b0;
    case (state)
      IDLE: begin
        if (s_rise) begin
          state_nx  = ARM;
          run_start = 1'b1;
        end
      end
      ARM: begin
        if (s_fall) begin
          state_nx = IDLE;
          abort    = 1'b1;
        end else if (buf_ready) begin
          state_nx  = COLLECT;
          start_win = 1'b1;
        end
      end
      COLLECT: begin
        if (win_end && last_win) begin
          state_nx = DONE;
        end else if (s_fall) begin
          state_nx = IDLE;
          abort    = 1'b1;
        end else if (win_end) begin
          if (gap_len_q != '0) begin
            state_nx = GAP;
          end else begin
            state_nx = ARM;
            next_win = 1'b1;
          end
        end
      end
      GAP: begin
        if (s_fall) begin
          state_nx = IDLE;
          abort    = 1'b1;
        end else if (gap_end) begin
          next_win = 1'b1;
          // The last gap cycle doubles as the ARM check, so a ready buffer sees exactly the gap between windows.
          if (buf_ready) begin
            state_nx  = COLLECT;
            start_win = 1'b1;
          end else begin
            state_nx = ARM;
          end
        end
      end
      DONE: begin
        state_nx = IDLE;
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk350 or posedge rstn) begin
    if (rstn) begin
      collect   <= 1'b0;
      win_start <= 1'b0;
      aborted   <= 1'b0;
      stalled   <= 1'b0;
      win_idx   <= '0;
      win_len_q <= '0;
      gap_len_q <= '0;
      num_win_q <= '0;
      rem       <= '0;
      gap_cnt   <= '0;
    end else begin
      collect   <= 1'b0;
      win_start <= 1'b0;
      aborted   <= abort;
      if (run_start) begin
        win_len_q <= (cfg_win_len == '0) ? LEN_ONE : cfg_win_len;
        gap_len_q <= cfg_gap_len;
        num_win_q <= cfg_num_win;
        win_idx   <= '0;
        stalled   <= 1'b0;
      end
      if (next_win) begin
        win_idx <= win_idx + CNT_ONE;
      end
      if ((state == COLLECT) && !buf_ready) begin
        stalled <= 1'b1;
      end
      // rem counts collect-high cycles still owed after the current one.
      if (start_win) begin
        collect   <= 1'b1;
        win_start <= 1'b1;
        rem       <= win_len_q - LEN_ONE;
      end else if ((state == COLLECT) && (state_nx == COLLECT) && buf_ready && (rem != '0)) begin
        collect <= 1'b1;
        rem     <= rem - LEN_ONE;
      end
      if ((state == COLLECT) && (state_nx == GAP)) begin
        gap_cnt <= gap_len_q - LEN_ONE;
      end else if ((state == GAP) && (gap_cnt != '0)) begin
        gap_cnt <= gap_cnt - LEN_ONE;
      end
    end
  end

  assign busy = (state != IDLE);
  assign done = (state == DONE);

endmodule

// File: tb/tb_coll_scheduler.sv
// Directed and random runs of coll_scheduler, compared every cycle against a window-by-window reference walk.
module tb_coll_scheduler;
  localparam int L    = 340;
  localparam int NRUN = 26;

  logic        clk350 = 1'b0;
  logic        rstn;
  logic        start_coll;
  logic [15:0] cfg_win_len;
  logic [15:0] cfg_gap_len;
  logic [7:0]  cfg_num_win;
  logic        buf_ready;
  logic        collect;
  logic        win_start;
  logic [7:0]  win_idx;
  logic        busy;
  logic        done;
  logic        aborted;
  logic        stalled;

  int checks = 0;
  int passes = 0;
  int fails  = 0;
  int cur_run = 0;
  int cur_cyc = 0;

  // Reference timeline, indexed by clock edge within a run: ph 0 idle, 1 arm, 2 collect, 3 gap, 4 done.
  bit         br    [L];
  bit         e_col [L];
  bit         e_ws  [L];
  bit         e_ab  [L];
  bit         inc   [L];
  int         ph    [L];
  logic [7:0] e_idx [L];
  bit         e_st  [L];
  logic [7:0] held_idx;
  bit         held_st;

  always #5 clk350 = ~clk350;

  coll_scheduler dut (
    .clk350      (clk350),
    .rstn        (rstn),
    .start_coll  (start_coll),
    .cfg_win_len (cfg_win_len),
    .cfg_gap_len (cfg_gap_len),
    .cfg_num_win (cfg_num_win),
    .buf_ready   (buf_ready),
    .collect     (collect),
    .win_start   (win_start),
    .win_idx     (win_idx),
    .busy        (busy),
    .done        (done),
    .aborted     (aborted),
    .stalled     (stalled)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s run=%0d cyc=%0d observed=%0h expected=%0h", tag, cur_run, cur_cyc, obs, exp);
    end
  endtask

  task automatic build_model(input int wl, input int gl, input int nw, input int f);
    int w, e, n, k, x, ab;
    logic [7:0] idx;
    bit st;
    w = (wl == 0) ? 1 : wl;
    for (int i = 0; i < L; i++) begin
      ph[i] = 0; e_col[i] = 0; e_ws[i] = 0; e_ab[i] = 0; inc[i] = 0;
    end
    // Start is sampled at edge 1; two sync edges plus the edge register open the run at edge 4.
    ph[4] = 1;
    x = 5;
    k = 0;
    while (1) begin
      e = x;
      while (e < L && !br[e]) begin ph[e] = 1; e++; end
      if (e >= L) break;
      ph[e] = 2; e_col[e] = 1; e_ws[e] = 1; n = 1;
      while (n < w && e + 1 < L) begin
        e++;
        ph[e] = 2;
        if (br[e]) begin e_col[e] = 1; n++; end
      end
      if (n < w || e + 1 >= L) break;
      e++;
      if (nw != 0 && k == nw - 1) begin ph[e] = 4; break; end
      k++;
      if (gl == 0) begin
        ph[e] = 1; inc[e] = 1; x = e + 1;
      end else begin
        for (int g = 0; g < gl && e + g < L; g++) ph[e + g] = 3;
        x = e + gl;
        if (x >= L) break;
        inc[x] = 1;
      end
    end
    ab = f + 3;
    if (ab < L && ph[ab-1] >= 1 && ph[ab-1] <= 3 && ph[ab] != 4) begin
      for (int i = ab; i < L; i++) begin
        ph[i] = 0; e_col[i] = 0; e_ws[i] = 0; inc[i] = 0;
      end
      e_ab[ab] = 1;
    end
    idx = held_idx;
    st  = held_st;
    for (int i = 0; i < L; i++) begin
      if (i == 4) begin idx = 8'd0; st = 1'b0; end
      if (inc[i]) idx = idx + 8'd1;
      if (i > 0 && ph[i-1] == 2 && !br[i]) st = 1'b1;
      e_idx[i] = idx;
      e_st[i]  = st;
    end
    held_idx = idx;
    held_st  = st;
  endtask

  task automatic do_run(input int r, input int wl, input int gl, input int nw, input int f, input int mode,
                        output int ncol, output int nab, output int ndone);
    int ecol;
    cur_run = r;
    for (int i = 0; i < L; i++) begin
      if (mode == 0)      br[i] = 1'b1;
      else if (mode == 1) br[i] = !(i >= 7 && i <= 9);
      else                br[i] = ($urandom_range(0, 3) != 0);
    end
    build_model(wl, gl, nw, f);
    ncol = 0; nab = 0; ndone = 0; ecol = 0;
    for (int c = 0; c < L; c++) begin
      cur_cyc    = c;
      start_coll = (c >= 1 && c < f);
      buf_ready  = br[c];
      if (c <= 4) begin
        cfg_win_len = 16'(wl);
        cfg_gap_len = 16'(gl);
        cfg_num_win = 8'(nw);
      end else begin
        cfg_win_len = 16'd20;
        cfg_gap_len = 16'($urandom_range(0, 9));
        cfg_num_win = 8'($urandom_range(0, 9));
      end
      @(posedge clk350);
      @(negedge clk350);
      chk("collect",   32'(collect),   32'(e_col[c]));
      chk("win_start", 32'(win_start), 32'(e_ws[c]));
      chk("win_idx",   32'(win_idx),   32'(e_idx[c]));
      chk("busy",      32'(busy),      32'(ph[c] != 0));
      chk("done",      32'(done),      32'(ph[c] == 4));
      chk("aborted",   32'(aborted),   32'(e_ab[c]));
      chk("stalled",   32'(stalled),   32'(e_st[c]));
      if (collect) ncol++;
      if (aborted) nab++;
      if (done) ndone++;
      if (e_col[c]) ecol++;
    end
    chk("collect_total", 32'(ncol), 32'(ecol));
  endtask

  initial begin
    int ncol, nab, ndone, nbusy, lat, wl, gl, nw, f;
    rstn = 1'b1; start_coll = 1'b0; buf_ready = 1'b0;
    cfg_win_len = '0; cfg_gap_len = '0; cfg_num_win = '0;
    held_idx = 8'd0; held_st = 1'b0;
    repeat (3) @(negedge clk350);
    chk("rst_collect",   32'(collect),   32'd0);
    chk("rst_win_start", 32'(win_start), 32'd0);
    chk("rst_win_idx",   32'(win_idx),   32'd0);
    chk("rst_busy",      32'(busy),      32'd0);
    chk("rst_done",      32'(done),      32'd0);
    chk("rst_aborted",   32'(aborted),   32'd0);
    chk("rst_stalled",   32'(stalled),   32'd0);
    rstn = 1'b0;
    repeat (8) @(negedge clk350);

    do_run(0, 4, 3, 2, 300, 0, ncol, nab, ndone);
    chk("two_win_total", 32'(ncol), 32'd8);
    chk("two_win_done", 32'(ndone), 32'd1);
    do_run(1, 8, 0, 1, 300, 1, ncol, nab, ndone);
    chk("stall_total", 32'(ncol), 32'd8);
    chk("stall_sticky", 32'(stalled), 32'd1);
    do_run(2, 100, 0, 0, 230, 0, ncol, nab, ndone);
    chk("abort_idx", 32'(win_idx), 32'd2);
    chk("abort_pulses", 32'(nab), 32'd1);
    chk("abort_no_done", 32'(ndone), 32'd0);
    do_run(3, 0, 0, 3, 300, 0, ncol, nab, ndone);
    chk("zero_win_total", 32'(ncol), 32'd3);
    chk("zero_win_done", 32'(ndone), 32'd1);
    do_run(4, 3, 0, 1, 5, 0, ncol, nab, ndone);
    chk("done_over_abort_done", 32'(ndone), 32'd1);
    chk("done_over_abort_ab", 32'(nab), 32'd0);
    do_run(5, 5, 2, 2, 300, 0, ncol, nab, ndone);
    chk("cfg_latched_total", 32'(ncol), 32'd10);
    for (int r = 6; r < NRUN; r++) begin
      wl = int'($urandom_range(0, 6));
      gl = int'($urandom_range(0, 4));
      nw = int'($urandom_range(0, 4));
      f  = ($urandom_range(0, 1) == 1) ? 320 : int'($urandom_range(2, 200));
      do_run(r, wl, gl, nw, f, 2, ncol, nab, ndone);
    end

    // Reset in the middle of a window with start held high.
    cur_run = NRUN; cur_cyc = 0;
    cfg_win_len = 16'd50; cfg_gap_len = 16'd0; cfg_num_win = 8'd0;
    buf_ready = 1'b1; start_coll = 1'b0;
    repeat (4) @(negedge clk350);
    start_coll = 1'b1;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk350);
      if (collect) break;
    end
    chk("pre_rst_collect", 32'(collect), 32'd1);
    repeat (3) @(negedge clk350);
    #2 rstn = 1'b1;
    #1;
    chk("async_rst_collect", 32'(collect), 32'd0);
    chk("async_rst_busy",    32'(busy),    32'd0);
    chk("async_rst_aborted", 32'(aborted), 32'd0);
    @(negedge clk350);
    rstn = 1'b0;
    nbusy = 0;
    for (int n = 0; n < 30; n++) begin
      @(negedge clk350);
      if (busy || collect) nbusy++;
    end
    chk("no_run_after_rst", 32'(nbusy), 32'd0);
    chk("no_abort_after_rst", 32'(aborted), 32'd0);
    start_coll = 1'b0;
    repeat (4) @(negedge clk350);
    start_coll = 1'b1;
    lat = 0;
    for (int n = 0; n < 20; n++) begin
      @(posedge clk350);
      lat++;
      @(negedge clk350);
      if (collect) break;
    end
    chk("start_latency", 32'(lat), 32'd5);
    chk("latency_win_start", 32'(win_start), 32'd1);
    chk("latency_win_idx", 32'(win_idx), 32'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
